// File: rtl/writeback_stage_reg_if.sv
// MEM->WB bundle for the writeback stage register.
// The master drives the memory-stage side; the slave is the stage itself.
interface writeback_stage_reg_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  ValidM;
  logic                  StallW;
  logic                  FlushW;
  logic                  RegWriteM;
  logic [1:0]            WbSelM;
  logic [2:0]            Funct3M;
  logic [XLEN-1:0]       ALUOutM;
  logic [XLEN-1:0]       DataMemOutM;
  logic [XLEN-1:0]       PcM;
  logic [XLEN-1:0]       ImmM;
  logic [REG_ADDR_W-1:0] WriteAddressM;

  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] WriteAddressW;
  logic [XLEN-1:0]       RegInDataW;
  logic                  ValidW;
  logic                  MisalignW;
  logic [CNT_W-1:0]      RetireCount;

  modport master (
    output ValidM, StallW, FlushW, RegWriteM, WbSelM, Funct3M,
           ALUOutM, DataMemOutM, PcM, ImmM, WriteAddressM,
    input  RegWriteW, WriteAddressW, RegInDataW, ValidW, MisalignW, RetireCount
  );

  modport slave (
    input  ValidM, StallW, FlushW, RegWriteM, WbSelM, Funct3M,
           ALUOutM, DataMemOutM, PcM, ImmM, WriteAddressM,
    output RegWriteW, WriteAddressW, RegInDataW, ValidW, MisalignW, RetireCount
  );
endinterface

// File: rtl/writeback_stage_reg.sv
// RV32 MEM/WB register: result select, sub-word load extraction, misaligned-load
// detection, register-file write port and a retired-write counter.
module writeback_stage_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 rst,
  writeback_stage_reg_if.slave wb
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  LINK_OFS = XLEN'(4);

  logic [1:0]      off;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] resData;
  logic            isLoad;
  logic            misalign;
  logic            wrEn;

  assign off    = wb.ALUOutM[1:0];
  assign isLoad = (wb.WbSelM == 2'b01);

  always_comb begin
    byteSel = 8'h00;
    case (off)
      2'd0:    byteSel = wb.DataMemOutM[7:0];
      2'd1:    byteSel = wb.DataMemOutM[15:8];
      2'd2:    byteSel = wb.DataMemOutM[23:16];
      default: byteSel = wb.DataMemOutM[31:24];
    endcase
    halfSel = off[1] ? wb.DataMemOutM[31:16] : wb.DataMemOutM[15:0];
  end

  // Unlisted Funct3 encodings fall through to the word path, alignment rule included.
  always_comb begin
    loadData = wb.DataMemOutM;
    misalign = 1'b0;
    case (wb.Funct3M)
      3'b000: loadData = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b100: loadData = {{(XLEN-8){1'b0}}, byteSel};
      3'b001: begin
        loadData = {{(XLEN-16){halfSel[15]}}, halfSel};
        misalign = off[0];
      end
      3'b101: begin
        loadData = {{(XLEN-16){1'b0}}, halfSel};
        misalign = off[0];
      end
      default: begin
        loadData = wb.DataMemOutM;
        misalign = (off != 2'b00);
      end
    endcase
    misalign = misalign & isLoad;
  end

  // A misaligned load reports its faulting address on the data port.
  always_comb begin
    resData = wb.ALUOutM;
    case (wb.WbSelM)
      2'b00:   resData = wb.ALUOutM;
      2'b01:   resData = misalign ? wb.ALUOutM : loadData;
      2'b10:   resData = wb.PcM + LINK_OFS;
      default: resData = wb.ImmM;
    endcase
  end

  assign wrEn = wb.RegWriteM & wb.ValidM & ~misalign & (wb.WriteAddressM != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.RegWriteW     <= 1'b0;
      wb.WriteAddressW <= '0;
      wb.RegInDataW    <= '0;
      wb.ValidW        <= 1'b0;
      wb.MisalignW     <= 1'b0;
      wb.RetireCount   <= '0;
    end else begin
      // A write held across a stall commits only on the edge that releases it.
      if (wb.RegWriteW && !wb.StallW)
        wb.RetireCount <= wb.RetireCount + CNT_ONE;

      if (wb.FlushW || (!wb.StallW && !wb.ValidM)) begin
        wb.ValidW    <= 1'b0;
        wb.RegWriteW <= 1'b0;
        wb.MisalignW <= 1'b0;
      end else if (!wb.StallW) begin
        wb.ValidW        <= 1'b1;
        wb.RegWriteW     <= wrEn;
        wb.MisalignW     <= misalign;
        wb.WriteAddressW <= wb.WriteAddressM;
        wb.RegInDataW    <= resData;
      end
    end
  end

endmodule
